// File: rtl/vp_text_stream_pipeline.sv
// Text cell row pipeline: font ROM read, attribute shaping, colour expansion and a
// credit-guarded first-word-fall-through output FIFO so ROM results are never dropped.
module vp_text_stream_pipeline #(
   parameter int CHAR_WIDTH   = 16,
   parameter int CHAR_HEIGHT  = 20,
   parameter int COLOR_BITS   = 4,
   parameter int CHAR_BITS    = 10,
   parameter int ROW_BITS     = 5,
   parameter int FONT_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             flush,
   input  logic                             blink_phase,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [CHAR_BITS-1:0]             in_char,
   input  logic [ROW_BITS-1:0]              in_row,
   input  logic [COLOR_BITS-1:0]            in_fg,
   input  logic [COLOR_BITS-1:0]            in_bg,
   input  logic                             in_double,
   input  logic                             in_part,
   input  logic                             in_blink,
   input  logic                             in_invert,
   input  logic                             in_underline,
   output logic                             font_req,
   output logic [CHAR_BITS+ROW_BITS-1:0]    font_address,
   input  logic [CHAR_WIDTH-1:0]            font_bitmap,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [CHAR_WIDTH*COLOR_BITS-1:0] out_pixels
);

   localparam int PIX_W = CHAR_WIDTH * COLOR_BITS;
   localparam int HALF  = CHAR_WIDTH / 2;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [ROW_BITS:0]   ROW_LIMIT = (ROW_BITS + 1)'(CHAR_HEIGHT);
   localparam logic [ROW_BITS-1:0] UL_ROW    = ROW_BITS'(CHAR_HEIGHT - 1);

   typedef struct packed {
      logic [COLOR_BITS-1:0] fg;
      logic [COLOR_BITS-1:0] bg;
      logic [ROW_BITS-1:0]   row;
      logic                  dbl;
      logic                  part;
      logic                  blink;
      logic                  invert;
      logic                  underline;
   } attr_t;

   attr_t                   r_attr [FONT_LATENCY];
   logic [FONT_LATENCY-1:0] r_attrValid;
   logic [PIX_W-1:0]        r_fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0]        r_wrPtr;
   logic [PTR_W-1:0]        r_rdPtr;
   logic [CNT_W-1:0]        r_fifoCount;
   logic [CNT_W-1:0]        r_occupancy;

   logic                    w_accept;
   logic                    w_write;
   logic                    w_pop;
   attr_t                   w_head;
   logic [CHAR_WIDTH-1:0]   w_bits;
   logic [PIX_W-1:0]        w_pixels;

   // Occupancy counts both in-flight ROM reads and buffered results, so a slot is always free.
   assign in_ready     = reset & ~flush & (r_occupancy < CNT_W'(FIFO_DEPTH));
   assign w_accept     = in_valid & in_ready;
   assign font_req     = w_accept;
   assign font_address = reset ? {in_char, in_row} : '0;
   assign out_valid    = reset & (r_fifoCount != '0);
   assign w_pop        = out_valid & out_ready;
   assign out_pixels   = out_valid ? r_fifoMem[r_rdPtr] : '0;
   assign w_head       = r_attr[FONT_LATENCY-1];
   assign w_write      = r_attrValid[FONT_LATENCY-1];

   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         r_attrValid <= '0;
      end else begin
         r_attrValid[0] <= w_accept;
         for (int i = 1; i < FONT_LATENCY; i++) begin
            r_attrValid[i] <= r_attrValid[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      r_attr[0] <= '{fg: in_fg, bg: in_bg, row: in_row, dbl: in_double, part: in_part,
                     blink: in_blink, invert: in_invert, underline: in_underline};
      for (int i = 1; i < FONT_LATENCY; i++) begin
         r_attr[i] <= r_attr[i-1];
      end
   end

   // Shaping order matters: half-select, out-of-cell blanking, underline, blink, invert.
   always_comb begin
      w_bits   = font_bitmap;
      w_pixels = '0;
      if (w_head.dbl) begin
         for (int j = 0; j < HALF; j++) begin
            w_bits[2*j]   = w_head.part ? font_bitmap[j] : font_bitmap[HALF+j];
            w_bits[2*j+1] = w_head.part ? font_bitmap[j] : font_bitmap[HALF+j];
         end
      end
      if ({1'b0, w_head.row} >= ROW_LIMIT) w_bits = '0;
      if (w_head.underline && (w_head.row == UL_ROW)) w_bits = '1;
      if (w_head.blink && blink_phase) w_bits = '0;
      if (w_head.invert) w_bits = ~w_bits;
      for (int k = 0; k < CHAR_WIDTH; k++) begin
         w_pixels[k*COLOR_BITS +: COLOR_BITS] = w_bits[k] ? w_head.fg : w_head.bg;
      end
   end

   always_ff @(posedge clk) begin
      if (w_write) r_fifoMem[r_wrPtr] <= w_pixels;
   end

   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_fifoCount <= '0;
         r_occupancy <= '0;
      end else begin
         if (w_write) r_wrPtr <= r_wrPtr + PTR_W'(1);
         if (w_pop)   r_rdPtr <= r_rdPtr + PTR_W'(1);
         r_fifoCount <= r_fifoCount + CNT_W'(w_write) - CNT_W'(w_pop);
         r_occupancy <= r_occupancy + CNT_W'(w_accept) - CNT_W'(w_pop);
      end
   end

endmodule

// File: tb/tb_vp_text_stream_pipeline.sv
// Self-checking bench for vp_text_stream_pipeline: directed attribute cases plus randomized
// traffic scored against a pixel-level reference model and a behavioural font ROM.
module tb_vp_text_stream_pipeline;

   localparam int CW  = 16;
   localparam int CH  = 20;
   localparam int CB  = 4;
   localparam int CHB = 10;
   localparam int RB  = 5;
   localparam int FL  = 2;
   localparam int FD  = 4;
   localparam int PW  = CW * CB;
   localparam int AW  = CHB + RB;

   logic          clk = 1'b0;
   logic          reset, flush, blink_phase, in_valid, in_ready;
   logic [CHB-1:0] in_char;
   logic [RB-1:0]  in_row;
   logic [CB-1:0]  in_fg, in_bg;
   logic          in_double, in_part, in_blink, in_invert, in_underline;
   logic          font_req;
   logic [AW-1:0] font_address;
   logic [CW-1:0] font_bitmap;
   logic          out_valid, out_ready;
   logic [PW-1:0] out_pixels;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [CHB-1:0] ch;
      logic [RB-1:0]  row;
      logic [CB-1:0]  fg;
      logic [CB-1:0]  bg;
      logic           dbl, part, blink, inv, ul;
      int             cyc;
   } item_t;

   logic [CW-1:0] fontMem [0:(1<<AW)-1];
   logic [AW-1:0] romStage;
   item_t         pending[$];
   item_t         monItem;
   logic [PW-1:0] obsQ[$];
   logic [PW-1:0] expQ[$];
   bit            phaseAt[int];
   int            cyc = 0;

   vp_text_stream_pipeline #(
      .CHAR_WIDTH(CW), .CHAR_HEIGHT(CH), .COLOR_BITS(CB), .CHAR_BITS(CHB),
      .ROW_BITS(RB), .FONT_LATENCY(FL), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush), .blink_phase(blink_phase),
      .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_row(in_row),
      .in_fg(in_fg), .in_bg(in_bg), .in_double(in_double), .in_part(in_part),
      .in_blink(in_blink), .in_invert(in_invert), .in_underline(in_underline),
      .font_req(font_req), .font_address(font_address), .font_bitmap(font_bitmap),
      .out_valid(out_valid), .out_ready(out_ready), .out_pixels(out_pixels)
   );

   always #5 clk = ~clk;

   // Font ROM with two cycles of fixed latency; it answers every cycle, requested or not.
   always @(posedge clk) begin
      romStage    <= font_address;
      font_bitmap <= fontMem[romStage];
   end

   // Reference pixel row computed directly from the shaping rules, pixel by pixel.
   function automatic logic [PW-1:0] expectPixels(input item_t it, input logic [CW-1:0] bm,
                                                  input logic phase);
      bit            on [CW];
      logic [PW-1:0] r = '0;
      int            src;
      for (int i = 0; i < CW; i++) begin
         src   = it.dbl ? ((it.part ? CW/2 : 0) + i/2) : i;
         on[i] = bm[CW-1-src];
      end
      for (int i = 0; i < CW; i++) begin
         if (int'(it.row) >= CH) on[i] = 1'b0;
         if (it.ul && int'(it.row) == CH-1) on[i] = 1'b1;
         if (it.blink && phase) on[i] = 1'b0;
         if (it.inv) on[i] = !on[i];
         r = (r << CB) | PW'(on[i] ? it.fg : it.bg);
      end
      return r;
   endfunction

   // Monitor: records accepted items and every popped word with its model expectation.
   always @(posedge clk) begin
      phaseAt[cyc] = blink_phase;
      if (out_valid && out_ready) begin
         obsQ.push_back(out_pixels);
         if (pending.size() > 0) begin
            monItem = pending.pop_front();
            expQ.push_back(expectPixels(monItem, fontMem[{monItem.ch, monItem.row}],
                                        phaseAt[monItem.cyc + FL]));
         end else begin
            expQ.push_back('x);
         end
      end
      if (!reset || flush) begin
         pending.delete();
      end else if (in_valid && in_ready) begin
         pending.push_back('{ch: in_char, row: in_row, fg: in_fg, bg: in_bg, dbl: in_double,
                             part: in_part, blink: in_blink, inv: in_invert,
                             ul: in_underline, cyc: cyc});
      end
      cyc++;
   end

   task automatic driveItem(input item_t it);
      in_char      = it.ch;
      in_row       = it.row;
      in_fg        = it.fg;
      in_bg        = it.bg;
      in_double    = it.dbl;
      in_part      = it.part;
      in_blink     = it.blink;
      in_invert    = it.inv;
      in_underline = it.ul;
   endtask

   function automatic item_t randItem();
      item_t it;
      it.ch    = CHB'($urandom);
      it.row   = RB'($urandom_range(0, 31));
      it.fg    = CB'($urandom);
      it.bg    = CB'($urandom);
      it.dbl   = 1'($urandom_range(0, 1));
      it.part  = 1'($urandom_range(0, 1));
      it.blink = 1'($urandom_range(0, 1));
      it.inv   = 1'($urandom_range(0, 1));
      it.ul    = 1'($urandom_range(0, 1));
      it.cyc   = 0;
      return it;
   endfunction

   function automatic item_t baseItem();
      item_t it;
      it = '{ch: 10'h041, row: 5'd3, fg: 4'hA, bg: 4'h5, dbl: 1'b0, part: 1'b0,
             blink: 1'b0, inv: 1'b0, ul: 1'b0, cyc: 0};
      return it;
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      driveItem(baseItem());
      repeat (3) @(negedge clk);
      checks += 5;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
      if (font_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_font_req: got %b expected 0", font_req); end
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
      if (out_pixels !== '0) begin errors++; $display("[TB] FAIL reset_out_pixels: got %h expected 0", out_pixels); end
      if (font_address !== '0) begin errors++; $display("[TB] FAIL reset_font_address: got %h expected 0", font_address); end
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_basic();
      fontMem[15'h0823] = 16'hF00F;
      @(negedge clk);
      driveItem(baseItem());
      in_valid = 1'b1;
      #1;
      checks += 3;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_in_ready: got %b expected 1", in_ready); end
      if (font_req !== 1'b1) begin errors++; $display("[TB] FAIL basic_font_req: got %b expected 1", font_req); end
      if (font_address !== 15'h0823) begin errors++; $display("[TB] FAIL basic_font_address: got %h expected 0823", font_address); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_t1: got %b expected 0", out_valid); end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_t2: got %b expected 0", out_valid); end
      @(negedge clk);
      checks += 2;
      if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid_t3: got %b expected 1", out_valid); end
      if (out_pixels !== 64'hAAAA55555555AAAA) begin errors++; $display("[TB] FAIL basic_pixels: got %h expected AAAA55555555AAAA", out_pixels); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drained: got %b expected 0", out_valid); end
   endtask

   task automatic test_attributes();
      item_t         tbl [11];
      logic [CW-1:0] bm  [11];
      logic          ph  [11];
      logic [PW-1:0] exp [11];
      for (int i = 0; i < 11; i++) begin tbl[i] = baseItem(); ph[i] = 1'b0; end
      tbl[0].dbl = 1; bm[0] = 16'hC300; exp[0] = 64'hAAAA55555555AAAA;
      tbl[1].dbl = 1; tbl[1].part = 1; bm[1] = 16'h00C3; exp[1] = 64'hAAAA55555555AAAA;
      tbl[2].inv = 1; bm[2] = 16'hF00F; exp[2] = 64'h5555AAAAAAAA5555;
      tbl[3].ul = 1; tbl[3].row = 5'd19; bm[3] = 16'h0000; exp[3] = 64'hAAAAAAAAAAAAAAAA;
      tbl[4].blink = 1; ph[4] = 1; bm[4] = 16'hF00F; exp[4] = 64'h5555555555555555;
      tbl[5].row = 5'd25; bm[5] = 16'hFFFF; exp[5] = 64'h5555555555555555;
      tbl[6].row = 5'd25; tbl[6].inv = 1; bm[6] = 16'hFFFF; exp[6] = 64'hAAAAAAAAAAAAAAAA;
      tbl[7].blink = 1; bm[7] = 16'hF00F; exp[7] = 64'hAAAA55555555AAAA;
      tbl[8].ul = 1; bm[8] = 16'hF00F; exp[8] = 64'hAAAA55555555AAAA;
      tbl[9].ul = 1; tbl[9].row = 5'd19; tbl[9].blink = 1; ph[9] = 1; bm[9] = 16'h0000; exp[9] = 64'h5555555555555555;
      tbl[10].ul = 1; tbl[10].row = 5'd19; tbl[10].inv = 1; bm[10] = 16'h0F0F; exp[10] = 64'h5555555555555555;
      for (int i = 0; i < 11; i++) begin
         fontMem[{tbl[i].ch, tbl[i].row}] = bm[i];
         @(negedge clk);
         blink_phase = ph[i];
         driveItem(tbl[i]);
         in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         for (int k = 0; k < 8 && out_valid !== 1'b1; k++) @(negedge clk);
         checks++;
         if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL attr%0d_timeout: got out_valid %b expected 1", i, out_valid);
         end else if (out_pixels !== exp[i]) begin
            errors++;
            $display("[TB] FAIL attr%0d_pixels: got %h expected %h", i, out_pixels, exp[i]);
         end
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         blink_phase = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      int accepts = 0;
      int stalls = 0;
      obsQ.delete();
      expQ.delete();
      out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         driveItem(randItem());
         in_valid = 1'b1;
         #1;
         if (in_ready) accepts++;
      end
      checks += 2;
      if (accepts !== 4) begin errors++; $display("[TB] FAIL bp_accepts: got %0d expected 4", accepts); end
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_full: got %b expected 0", in_ready); end
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         out_ready = 1'b1;
         driveItem(randItem());
         #1;
         if (in_ready) accepts++;
         else if (c >= 1) stalls++;
      end
      checks++;
      if (stalls !== 0) begin errors++; $display("[TB] FAIL bp_throughput: got %0d stalls expected 0", stalls); end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (obsQ.size() !== accepts) begin errors++; $display("[TB] FAIL bp_count: got %0d expected %0d", obsQ.size(), accepts); end
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
         checks++;
         if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL bp_item%0d: got %h expected %h", i, obsQ[i], expQ[i]); end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      item_t d;
      int    lateValid = 0;
      out_ready = 1'b0;
      @(negedge clk); driveItem(randItem()); in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk); driveItem(randItem()); in_valid = 1'b1;
      @(negedge clk); driveItem(randItem());
      @(negedge clk); driveItem(randItem()); flush = 1'b1;
      #1;
      checks += 2;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_ready: got %b expected 0", in_ready); end
      if (font_req !== 1'b0) begin errors++; $display("[TB] FAIL flush_font_req: got %b expected 0", font_req); end
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid: got %b expected 0", out_valid); end
      repeat (2) begin
         @(negedge clk);
         if (out_valid !== 1'b0) lateValid++;
      end
      checks++;
      if (lateValid !== 0) begin errors++; $display("[TB] FAIL flush_late_rom: got %0d valid cycles expected 0", lateValid); end
      d = randItem();
      @(negedge clk); driveItem(d); in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_next_t1: got %b expected 0", out_valid); end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_next_t2: got %b expected 0", out_valid); end
      @(negedge clk);
      checks += 2;
      if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_next_t3: got %b expected 1", out_valid); end
      if (out_pixels !== expectPixels(d, fontMem[{d.ch, d.row}], blink_phase)) begin
         errors++;
         $display("[TB] FAIL flush_next_pixels: got %h expected %h", out_pixels,
                  expectPixels(d, fontMem[{d.ch, d.row}], blink_phase));
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_alone: got %b expected 0", out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_midstream();
      int staleValid = 0;
      int accepts = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         driveItem(randItem());
         in_valid = 1'b1;
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks += 5;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_in_ready: got %b expected 0", in_ready); end
      if (font_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_font_req: got %b expected 0", font_req); end
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_out_valid: got %b expected 0", out_valid); end
      if (out_pixels !== '0) begin errors++; $display("[TB] FAIL mid_reset_pixels: got %h expected 0", out_pixels); end
      if (font_address !== '0) begin errors++; $display("[TB] FAIL mid_reset_address: got %h expected 0", font_address); end
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (out_valid !== 1'b0 || out_pixels !== '0) staleValid++;
         @(negedge clk);
      end
      checks++;
      if (staleValid !== 0) begin errors++; $display("[TB] FAIL mid_reset_stale: got %0d stale cycles expected 0", staleValid); end
      obsQ.delete();
      expQ.delete();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         driveItem(randItem());
         in_valid = 1'b1;
         #1;
         if (in_ready) accepts++;
      end
      checks++;
      if (accepts !== 20) begin errors++; $display("[TB] FAIL mid_reset_throughput: got %0d expected 20", accepts); end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if (obsQ.size() !== 20) begin errors++; $display("[TB] FAIL mid_reset_count: got %0d expected 20", obsQ.size()); end
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
         checks++;
         if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL mid_reset_item%0d: got %h expected %h", i, obsQ[i], expQ[i]); end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      obsQ.delete();
      expQ.delete();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         driveItem(randItem());
         in_valid    = ($urandom_range(0, 9) < 7);
         out_ready   = ($urandom_range(0, 9) < 6);
         blink_phase = 1'($urandom_range(0, 1));
         flush       = ($urandom_range(0, 99) < 2);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (12) @(negedge clk);
      checks++;
      if (pending.size() !== 0) begin errors++; $display("[TB] FAIL random_lost: got %0d undelivered expected 0", pending.size()); end
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
         checks++;
         if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL random_item%0d: got %h expected %h", i, obsQ[i], expQ[i]); end
      end
   endtask

   initial begin
      reset       = 1'b0;
      flush       = 1'b0;
      blink_phase = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      driveItem(baseItem());
      for (int i = 0; i < (1 << AW); i++) fontMem[i] = CW'($urandom);
      test_reset();
      test_basic();
      test_attributes();
      test_back_to_back();
      test_flush();
      test_reset_midstream();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vp_text_stream_pipeline.md
Name: vp_text_stream_pipeline

Overview:
Parametrised, back-pressurable successor of the text path of the video pipeline. It accepts one character cell row per handshake and issues a fixed-latency font ROM read. It applies double-width, blink, underline and invert to the returned row bitmap, expands it to packed colour pixels, and buffers results in an output FIFO. Admission is credit-based, so ROM results are never dropped when the downstream stalls.

Parameters:
CHAR_WIDTH, 16, pixels per cell row (even, ≥2); font bitmap width.
CHAR_HEIGHT, 20, rows per cell; row CHAR_HEIGHT-1 is the underline row.
COLOR_BITS, 4, bits per colour index.
CHAR_BITS, 10, character code width.
ROW_BITS, 5, row index width.
FONT_LATENCY, 2, cycles from font_req to valid font_bitmap (≥1, fixed, ROM never stalls).
FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2; ≥FONT_LATENCY+2 required for 1 item/cycle).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
flush  in  1  synchronous drop of all in-flight and buffered items
blink_phase  in  1  global blink phase; 1 = blinking cells hidden
in_valid  in  1  input item valid
in_ready  out  1  input may be accepted
in_char  in  CHAR_BITS  character code
in_row  in  ROW_BITS  row within cell
in_fg  in  COLOR_BITS  foreground colour
in_bg  in  COLOR_BITS  background colour
in_double  in  1  double-width character
in_part  in  1  0 = left half, 1 = right half (when in_double)
in_blink, in_invert, in_underline  in  1 each  attributes
font_req  out  1  font read strobe
font_address  out  CHAR_BITS+ROW_BITS  {in_char, in_row}
font_bitmap  in  CHAR_WIDTH  row bitmap, MSB = leftmost pixel
out_valid  out  1  output item valid
out_ready  in  1  downstream accepts
out_pixels  out  CHAR_WIDTH*COLOR_BITS  pixel 0 (leftmost) in the most-significant COLOR_BITS

Behaviour:
- Accept when in_valid & in_ready (cycle T). font_req = in_valid & in_ready, and font_address = {in_char,in_row}; both are combinational.
- Attributes (fg, bg, row, double, part, blink, invert, underline) travel in a FONT_LATENCY-deep valid-tagged delay line.
- At cycle T+FONT_LATENCY, the bitmap b is processed in this order:
  (1) if double: take the MSB half (part=0) or LSB half (part=1) and replicate each bit twice, preserving order.
  (2) if underline & row==CHAR_HEIGHT-1: b = all ones.
  (3) if blink & blink_phase (sampled at T+FONT_LATENCY): b = 0.
  (4) if invert: b = ~b.
  (5) pixel i = b[CHAR_WIDTH-1-i] ? fg : bg.
- If row ≥ CHAR_HEIGHT: b = 0 before step 2, so the output is background or, if inverted, foreground.
- The result is written to the FIFO at the end of T+FONT_LATENCY. The FIFO is first-word fall-through, so out_valid rises at T+FONT_LATENCY+1 if the FIFO was empty. Latency is FONT_LATENCY+1.
- Pop when out_valid & out_ready. out_pixels is held stable while out_valid & !out_ready.
- Credit counter:
  - occupancy = in-flight (accepted, not yet written) + FIFO count.
  - in_ready = reset & !flush & (occupancy < FIFO_DEPTH).
  - A pop in the current cycle does not free credit until the next cycle.
  - Simultaneous accept, write and pop update the counts correctly in the same cycle.
- Overflow cannot occur. Asserting in_valid while in_ready=0 has no effect; the input is not consumed.
- flush:
  - Clears the delay-line valids, the FIFO pointers and the counts at the end of the cycle.
  - font_req=0 during flush.
  - out_valid=0 from the next cycle.
  - ROM data returning for flushed requests is ignored.
- Reset (reset=0), which may occur mid-operation:
  - in_ready=0, font_req=0, out_valid=0, out_pixels=0, all counts/pointers/valids=0. Combinational outputs are forced low during reset.
  - Normal operation begins on the first cycle with reset=1.
- Item order is strictly preserved. Data is don't-care when out_valid=0; the implementation drives 0 after reset.

Test Plan:
- Defaults; accept {char 0x041, row 3, fg 0xA, bg 0x5}; font_bitmap 0xF00F at T+2 → out_valid at T+3, out_pixels 0xAAAA55555555AAAA, font_address 0x0823.
- The same item with in_double=1, part=0, bitmap 0xC300 → 0xAAAA55555555AAAA. With part=1 and bitmap 0x00C3 → same result.
- Attributes:
  - invert with 0xF00F → 0x5555AAAAAAAA5555.
  - underline, row 19, bitmap 0 → 0xAAAAAAAAAAAAAAAA.
  - blink with blink_phase=1 → 0x5555555555555555.
  - row 25, no attributes → all 0x5.
- Back-pressure: out_ready=0, in_valid held high → exactly 4 accepts, then in_ready=0. Release out_ready → 4 items emerge in order, and streaming resumes at 1 item/cycle.
- Flush with 2 items in flight and 1 buffered → out_valid=0 next cycle. Late ROM data is ignored. The next accepted item emerges alone after 3 cycles.
- Reset asserted mid-stream for 1 cycle → all outputs 0 that cycle and after. Full throughput resumes with no stale items.
